// File: rtl/i2c_target.sv
// I2C target (slave) core: answers one 7-bit address, delivers written bytes on a local
// byte interface and fetches read bytes from it. SDA is open-drain: 0 pulls low, 1 releases.
module i2c_target #(
    parameter logic [6:0] ADDR        = 7'h50,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_o,
    output logic       sda_oen_o,
    input  logic       ack_en,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_first,
    output logic       tx_req,
    input  logic [7:0] tx_data,
    output logic       start_o,
    output logic       stop_o,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ADDR      = 3'd1,
        S_ADDR_ACK  = 3'd2,
        S_WR_DATA   = 3'd3,
        S_WR_ACK    = 3'd4,
        S_RD_DATA   = 3'd5,
        S_RD_ACK    = 3'd6,
        S_WAIT_STOP = 3'd7
    } state_t;

    logic [SYNC_STAGES-1:0] r_scl_sync;
    logic [SYNC_STAGES-1:0] r_sda_sync;
    logic                   r_scl_prev;
    logic                   r_sda_prev;
    logic                   w_scl;
    logic                   w_sda;
    logic                   w_scl_rise;
    logic                   w_scl_fall;
    logic                   w_start;
    logic                   w_stop;

    state_t     r_state;
    logic [2:0] r_bitcnt;
    logic [6:0] r_shift;
    logic       r_phase;
    logic       r_rw;
    logic       r_first;
    logic       r_ack_low;
    logic       r_sda;
    logic [7:0] r_rx_data;
    logic       r_rx_valid;
    logic       r_rx_first;
    logic       r_tx_req;
    logic       r_start;
    logic       r_stop;
    logic       r_busy;

    assign w_scl      = r_scl_sync[SYNC_STAGES-1];
    assign w_sda      = r_sda_sync[SYNC_STAGES-1];
    assign w_scl_rise = w_scl & ~r_scl_prev;
    assign w_scl_fall = ~w_scl & r_scl_prev;
    assign w_start    = r_scl_prev & w_scl & r_sda_prev & ~w_sda;
    assign w_stop     = r_scl_prev & w_scl & ~r_sda_prev & w_sda;

    assign sda_o     = r_sda;
    assign sda_oen_o = r_sda;
    assign rx_data   = r_rx_data;
    assign rx_valid  = r_rx_valid;
    assign rx_first  = r_rx_first;
    assign tx_req    = r_tx_req;
    assign start_o   = r_start;
    assign stop_o    = r_stop;
    assign busy      = r_busy;

    // Pin synchronizers; reset to the idle-bus level so no false edge appears after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_prev <= 1'b1;
            r_sda_prev <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl_i};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_i};
            r_scl_prev <= w_scl;
            r_sda_prev <= w_sda;
        end
    end

    // Protocol FSM; START/STOP take priority over any bit-level activity.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_bitcnt   <= 3'd0;
            r_shift    <= 7'd0;
            r_phase    <= 1'b0;
            r_rw       <= 1'b0;
            r_first    <= 1'b0;
            r_ack_low  <= 1'b0;
            r_sda      <= 1'b1;
            r_rx_data  <= 8'd0;
            r_rx_valid <= 1'b0;
            r_rx_first <= 1'b0;
            r_tx_req   <= 1'b0;
            r_start    <= 1'b0;
            r_stop     <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            r_rx_first <= 1'b0;
            r_tx_req   <= 1'b0;
            r_start    <= 1'b0;
            r_stop     <= 1'b0;
            if (w_start) begin
                r_start  <= 1'b1;
                r_state  <= S_ADDR;
                r_bitcnt <= 3'd0;
                r_phase  <= 1'b0;
                r_sda    <= 1'b1;
                r_busy   <= 1'b0;
            end else if (w_stop) begin
                r_stop   <= 1'b1;
                r_state  <= S_IDLE;
                r_bitcnt <= 3'd0;
                r_phase  <= 1'b0;
                r_sda    <= 1'b1;
                r_busy   <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_sda <= 1'b1;
                    end
                    S_ADDR: begin
                        if (w_scl_rise) begin
                            r_shift  <= {r_shift[5:0], w_sda};
                            r_bitcnt <= r_bitcnt + 3'd1;
                            if (r_bitcnt == 3'd7) begin
                                r_bitcnt <= 3'd0;
                                r_phase  <= 1'b0;
                                if (r_shift == ADDR) begin
                                    r_rw    <= w_sda;
                                    r_busy  <= 1'b1;
                                    r_first <= 1'b1;
                                    r_state <= S_ADDR_ACK;
                                end else begin
                                    r_state <= S_WAIT_STOP;
                                end
                            end
                        end
                    end
                    // phase 0: waiting to pull low; phase 1: holding the ACK low
                    S_ADDR_ACK: begin
                        if (w_scl_fall) begin
                            if (!r_phase) begin
                                r_sda   <= 1'b0;
                                r_phase <= 1'b1;
                            end else begin
                                r_phase  <= 1'b0;
                                r_bitcnt <= 3'd0;
                                if (r_rw) begin
                                    r_shift <= tx_data[6:0];
                                    r_sda   <= tx_data[7];
                                    r_state <= S_RD_DATA;
                                end else begin
                                    r_sda   <= 1'b1;
                                    r_state <= S_WR_DATA;
                                end
                            end
                        end else if (w_scl_rise && r_phase && r_rw) begin
                            r_tx_req <= 1'b1;
                        end
                    end
                    S_WR_DATA: begin
                        if (w_scl_rise) begin
                            r_shift  <= {r_shift[5:0], w_sda};
                            r_bitcnt <= r_bitcnt + 3'd1;
                            if (r_bitcnt == 3'd7) begin
                                r_bitcnt   <= 3'd0;
                                r_rx_data  <= {r_shift, w_sda};
                                r_first    <= 1'b0;
                                r_ack_low  <= ack_en;
                                r_rx_valid <= ack_en;
                                r_rx_first <= ack_en & r_first;
                                r_phase    <= 1'b0;
                                r_state    <= S_WR_ACK;
                            end
                        end
                    end
                    S_WR_ACK: begin
                        if (w_scl_fall) begin
                            if (!r_phase) begin
                                r_sda   <= ~r_ack_low;
                                r_phase <= 1'b1;
                            end else begin
                                r_sda   <= 1'b1;
                                r_phase <= 1'b0;
                                r_state <= S_WR_DATA;
                            end
                        end
                    end
                    // MSB already on the line at entry; r_phase marks all 8 bits clocked out
                    S_RD_DATA: begin
                        if (w_scl_rise) begin
                            r_bitcnt <= r_bitcnt + 3'd1;
                            if (r_bitcnt == 3'd7) begin
                                r_bitcnt <= 3'd0;
                                r_phase  <= 1'b1;
                            end
                        end else if (w_scl_fall) begin
                            if (r_phase) begin
                                r_sda   <= 1'b1;
                                r_phase <= 1'b0;
                                r_state <= S_RD_ACK;
                            end else begin
                                r_sda   <= r_shift[6];
                                r_shift <= {r_shift[5:0], 1'b0};
                            end
                        end
                    end
                    S_RD_ACK: begin
                        if (w_scl_rise && !r_phase) begin
                            if (!w_sda) begin
                                r_tx_req <= 1'b1;
                                r_phase  <= 1'b1;
                            end else begin
                                r_state <= S_WAIT_STOP;
                            end
                        end else if (w_scl_fall && r_phase) begin
                            r_phase  <= 1'b0;
                            r_bitcnt <= 3'd0;
                            r_shift  <= tx_data[6:0];
                            r_sda    <= tx_data[7];
                            r_state  <= S_RD_DATA;
                        end
                    end
                    S_WAIT_STOP: begin
                        r_sda <= 1'b1;
                    end
                    default: begin
                        r_sda   <= 1'b1;
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: a bit-banged controller on a wired-AND SDA line,
// with pulse counters and a write-byte log kept by a monitor.
module tb_i2c_target;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       scl;
    logic       sda_m;
    logic       sda_line;
    logic       sda_o;
    logic       sda_oen_o;
    logic       ack_en;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_first;
    logic       tx_req;
    logic [7:0] tx_data;
    logic       start_o;
    logic       stop_o;
    logic       busy;

    int total = 0;
    int bad   = 0;

    int         rx_cnt = 0;
    int         tx_cnt = 0;
    int         st_cnt = 0;
    int         sp_cnt = 0;
    logic [8:0] rx_log [0:15];

    assign sda_line = sda_m & sda_o;

    i2c_target #(.ADDR(7'h50), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .scl_i     (scl),
        .sda_i     (sda_line),
        .sda_o     (sda_o),
        .sda_oen_o (sda_oen_o),
        .ack_en    (ack_en),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_first  (rx_first),
        .tx_req    (tx_req),
        .tx_data   (tx_data),
        .start_o   (start_o),
        .stop_o    (stop_o),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Pulse counters and accepted-byte log
    always @(posedge clk) begin
        if (rx_valid) begin
            rx_log[rx_cnt[3:0]] <= {rx_first, rx_data};
            rx_cnt <= rx_cnt + 1;
        end
        if (tx_req)  tx_cnt <= tx_cnt + 1;
        if (start_o) st_cnt <= st_cnt + 1;
        if (stop_o)  sp_cnt <= sp_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wq();
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; wq();
        scl   = 1'b1; wq();
        sda_m = 1'b0; wq();
        scl   = 1'b0; wq();
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wq();
        scl   = 1'b1; wq();
        sda_m = 1'b1; wq();
    endtask

    task automatic bit_xfer(input logic b, output logic r);
        sda_m = b; wq();
        scl   = 1'b1; wq();
        r     = sda_line; wq();
        scl   = 1'b0; wq();
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic dummy;
        for (int i = 7; i >= 0; i--) bit_xfer(d[i], dummy);
        bit_xfer(1'b1, ack);
    endtask

    task automatic read_byte(input logic ack_bit, output logic [7:0] d);
        logic dummy;
        for (int i = 7; i >= 0; i--) bit_xfer(1'b1, d[i]);
        bit_xfer(ack_bit, dummy);
    endtask

    initial begin
        logic       ack;
        logic       dummy;
        logic [7:0] rd;
        int         rx0, tx0, st0, sp0;

        rst_n = 1'b0; scl = 1'b1; sda_m = 1'b1; ack_en = 1'b1; tx_data = 8'h00;
        repeat (5) @(posedge clk);
        #1;
        chk("rst_sda_o",    {31'd0, sda_o},     32'd1);
        chk("rst_sda_oen",  {31'd0, sda_oen_o}, 32'd1);
        chk("rst_rx_data",  {24'd0, rx_data},   32'd0);
        chk("rst_busy",     {31'd0, busy},      32'd0);
        chk("rst_pulses",   {27'd0, rx_valid, rx_first, tx_req, start_o, stop_o}, 32'd0);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        // Write 0xA5, 0x3C to address 0x50
        rx0 = rx_cnt; sp0 = sp_cnt;
        i2c_start();
        write_byte(8'hA0, ack); chk("w_addr_ack", {31'd0, ack}, 32'd0);
        chk("w_busy", {31'd0, busy}, 32'd1);
        write_byte(8'hA5, ack); chk("w_d0_ack", {31'd0, ack}, 32'd0);
        write_byte(8'h3C, ack); chk("w_d1_ack", {31'd0, ack}, 32'd0);
        chk("w_rx_cnt", rx_cnt - rx0, 32'd2);
        chk("w_log0", {23'd0, rx_log[rx0[3:0]]},     {23'd0, 9'h1A5});
        chk("w_log1", {23'd0, rx_log[rx0[3:0] + 4'd1]}, {23'd0, 9'h03C});
        i2c_stop();
        chk("w_stop_pulse", sp_cnt - sp0, 32'd1);
        chk("w_busy_end", {31'd0, busy}, 32'd0);

        // Address 0x51 is not ours
        rx0 = rx_cnt; tx0 = tx_cnt;
        i2c_start();
        write_byte(8'hA2, ack); chk("nm_ack", {31'd0, ack}, 32'd1);
        chk("nm_busy", {31'd0, busy}, 32'd0);
        write_byte(8'h55, ack); chk("nm_data_ack", {31'd0, ack}, 32'd1);
        i2c_stop();
        chk("nm_rx", rx_cnt - rx0, 32'd0);
        chk("nm_tx", tx_cnt - tx0, 32'd0);

        // Read 0x96 (ACK) then 0x5A (NACK)
        tx0 = tx_cnt; tx_data = 8'h96;
        i2c_start();
        write_byte(8'hA1, ack); chk("r_addr_ack", {31'd0, ack}, 32'd0);
        tx_data = 8'h5A;
        read_byte(1'b0, rd); chk("r_byte0", {24'd0, rd}, 32'h96);
        read_byte(1'b1, rd); chk("r_byte1", {24'd0, rd}, 32'h5A);
        chk("r_tx_req", tx_cnt - tx0, 32'd2);
        wq();
        chk("r_released", {31'd0, sda_o}, 32'd1);
        i2c_stop();

        // Write 0x10, repeated START, read one byte
        rx0 = rx_cnt; st0 = st_cnt; sp0 = sp_cnt;
        i2c_start();
        write_byte(8'hA0, ack); chk("rs_waddr_ack", {31'd0, ack}, 32'd0);
        write_byte(8'h10, ack); chk("rs_wdata_ack", {31'd0, ack}, 32'd0);
        tx_data = 8'hC3;
        i2c_start();
        chk("rs_busy_cleared", {31'd0, busy}, 32'd0);
        write_byte(8'hA1, ack); chk("rs_raddr_ack", {31'd0, ack}, 32'd0);
        read_byte(1'b1, rd); chk("rs_rdata", {24'd0, rd}, 32'hC3);
        chk("rs_no_stop", sp_cnt - sp0, 32'd0);
        i2c_stop();
        chk("rs_starts", st_cnt - st0, 32'd2);
        chk("rs_rx_cnt", rx_cnt - rx0, 32'd1);
        chk("rs_log", {23'd0, rx_log[rx0[3:0]]}, {23'd0, 9'h110});

        // Data NACKed when ack_en=0
        rx0 = rx_cnt; ack_en = 1'b0;
        i2c_start();
        write_byte(8'hA0, ack); chk("ne_addr_ack", {31'd0, ack}, 32'd0);
        write_byte(8'h77, ack); chk("ne_data_nack", {31'd0, ack}, 32'd1);
        chk("ne_rx_data", {24'd0, rx_data}, 32'h77);
        i2c_stop();
        chk("ne_no_valid", rx_cnt - rx0, 32'd0);
        ack_en = 1'b1;

        // Reset while the target holds the address ACK low
        i2c_start();
        for (int i = 7; i >= 0; i--) bit_xfer(((8'hA0 >> i) & 8'h01) != 8'h00, dummy);
        sda_m = 1'b1; wq();
        chk("ra_driving", {31'd0, sda_o}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("ra_async_sda", {30'd0, sda_o, sda_oen_o}, 32'd3);
        wq();
        rst_n = 1'b1;
        scl = 1'b1; wq(); wq();
        scl = 1'b0; wq();
        i2c_stop();
        rx0 = rx_cnt;
        i2c_start();
        write_byte(8'hA0, ack); chk("ra_addr_ack", {31'd0, ack}, 32'd0);
        write_byte(8'hE7, ack); chk("ra_data_ack", {31'd0, ack}, 32'd0);
        i2c_stop();
        chk("ra_rx_cnt", rx_cnt - rx0, 32'd1);
        chk("ra_log", {23'd0, rx_log[rx0[3:0]]}, {23'd0, 9'h1E7});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
